vec_serialize: RTL



---
 rtl/vec_serialize.sv | 63 ++++++
 1 files changed

// File: rtl/vec_serialize.sv
// vec_serialize: takes one packed float vector per handshake and streams its elements
// out lowest index first, flagging the last one.
module vec_serialize #(
    parameter int EXP_WIDTH = 8,
    parameter int MANTISSA_WIDTH = 23,
    parameter int BIAS = 127,
    parameter int VEC_SIZE = 4,
    localparam int W = 1 + EXP_WIDTH + MANTISSA_WIDTH,
    localparam int IDX_W = VEC_SIZE > 1 ? $clog2(VEC_SIZE) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [VEC_SIZE*W-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [W-1:0]          out_data,
    output logic [IDX_W-1:0]      out_index,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    if (VEC_SIZE < 1) begin : g_bad_size
        $error("VEC_SIZE=%0d must be at least 1 (BIAS=%0d)", VEC_SIZE, BIAS);
    end

    logic [0:0]            state;
    logic [IDX_W-1:0]      idx;
    logic [VEC_SIZE*W-1:0] hold;
    logic                  in_hs;
    logic                  out_hs;

    assign out_valid = state == SEND;
    assign out_index = idx;
    assign out_last  = out_valid && idx == IDX_W'(VEC_SIZE - 1);
    // A vector can be taken in the same cycle the last element leaves, so streams have no bubble.
    assign in_ready  = rst_n && (state == IDLE || (out_ready && out_last));
    assign in_hs     = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;

    always_comb begin
        out_data = '0;
        for (int i = 0; i < VEC_SIZE; i++)
            if (idx == IDX_W'(i)) out_data = hold[i*W +: W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            hold  <= '0;
        end else if (in_hs) begin
            state <= SEND;
            idx   <= '0;
            hold  <= in_data;
        end else if (out_hs) begin
            state <= out_last ? IDLE : SEND;
            idx   <= out_last ? '0 : idx + 1'b1;
        end
    end
endmodule
